tff_bank: RTL and testbench

Parametrised successor to the single-bit toggle flip-flop. It holds a bank of CHANNELS toggle flip-flops with synchronised T inputs and four run modes: level-toggle, edge-toggle, hold, and ripple-free binary counter. It also provides a synchronous parallel load and a wrapping activity counter with a sticky overflow flag. It sits directly behind the dedicated input pins: ui_in supplies t_in and mode/load controls, uo_out carries q and status.

---
 rtl/tff_bank.sv | 91 +++++++++
 tb/tb_tff_bank.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tff_bank.sv
// Bank of CHANNELS toggle flip-flops behind a per-bit synchroniser, with four run modes,
// synchronous parallel load and a wrapping activity counter with a sticky overflow flag.
module tff_bank #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [CHANNELS-1:0] t_in,
    input  logic [1:0]          mode,
    input  logic                load,
    input  logic [CHANNELS-1:0] load_val,
    output logic [CHANNELS-1:0] q,
    output logic [CNT_W-1:0]    toggle_cnt,
    output logic                cnt_ovf
);

    localparam logic [1:0] MODE_LEVEL = 2'b00;
    localparam logic [1:0] MODE_EDGE  = 2'b01;
    localparam logic [1:0] MODE_HOLD  = 2'b10;

    logic [CHANNELS-1:0] sync_ff [SYNC_STAGES];
    logic [CHANNELS-1:0] t_sync;
    logic [CHANNELS-1:0] t_prev;
    logic [CHANNELS-1:0] q_next;
    logic                carry;
    logic                changed;

    assign t_sync = sync_ff[SYNC_STAGES-1];

    // Synchroniser and edge history run free of ena/mode/load, so edges seen while
    // disabled are consumed rather than queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_ff[s] <= '0;
            end
            t_prev <= '0;
        end else begin
            sync_ff[0] <= t_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_ff[s] <= sync_ff[s-1];
            end
            t_prev <= t_sync;
        end
    end

    always_comb begin
        q_next = q;
        carry  = t_sync[0];
        case (mode)
            MODE_LEVEL: q_next = q ^ t_sync;
            MODE_EDGE:  q_next = q ^ (t_sync & ~t_prev);
            MODE_HOLD:  q_next = q;
            default: begin
                // Ripple-free counter: bit i toggles when all lower bits are one.
                for (int i = 0; i < CHANNELS; i++) begin
                    q_next[i] = q[i] ^ carry;
                    carry     = carry & q[i];
                end
            end
        endcase
    end

    assign changed = (q_next != q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q          <= '0;
            toggle_cnt <= '0;
            cnt_ovf    <= 1'b0;
        end else if (ena) begin
            if (load) begin
                q          <= load_val;
                toggle_cnt <= '0;
                cnt_ovf    <= 1'b0;
            end else begin
                q <= q_next;
                if (changed) begin
                    toggle_cnt <= toggle_cnt + 1'b1;
                    if (&toggle_cnt) begin
                        cnt_ovf <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tff_bank.sv
// Bench for tff_bank: hand-derived vector table, directed multi-cycle sequences and
// randomized traffic checked against a behavioural model through an expected-value queue.
module tb_tff_bank;

    localparam int CH = 4;
    localparam int SS = 2;
    localparam int CW = 4;
    localparam int EW = CH + CW + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic [CH-1:0] t_in;
    logic [1:0]    mode;
    logic          load;
    logic [CH-1:0] load_val;
    logic [CH-1:0] q;
    logic [CW-1:0] toggle_cnt;
    logic          cnt_ovf;

    int checks = 0;
    int errors = 0;

    tff_bank #(.CHANNELS(CH), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .t_in       (t_in),
        .mode       (mode),
        .load       (load),
        .load_val   (load_val),
        .q          (q),
        .toggle_cnt (toggle_cnt),
        .cnt_ovf    (cnt_ovf)
    );

    always #5 clk = ~clk;

    // Behavioural model: t_in samples taken at each edge, q as a number.
    logic [CH-1:0] hist[$];
    int            m_q;
    int            m_cnt;
    bit            m_ovf;
    logic [EW-1:0] exp_q[$];

    task automatic model_reset();
        hist.delete();
        repeat (SS + 1) hist.push_back('0);
        m_q   = 0;
        m_cnt = 0;
        m_ovf = 0;
    endtask

    task automatic model_edge();
        logic [CH-1:0] ts;
        logic [CH-1:0] tp;
        int            nq;
        ts = hist[1];
        tp = hist[0];
        if (ena) begin
            if (load) begin
                m_q   = int'(load_val);
                m_cnt = 0;
                m_ovf = 0;
            end else begin
                case (mode)
                    2'd0:    nq = m_q ^ int'(ts);
                    2'd1:    nq = m_q ^ int'(ts & ~tp);
                    2'd2:    nq = m_q;
                    default: nq = ts[0] ? (m_q + 1) % (1 << CH) : m_q;
                endcase
                if (nq != m_q) begin
                    if (m_cnt == (1 << CW) - 1) m_ovf = 1;
                    m_cnt = (m_cnt + 1) % (1 << CW);
                end
                m_q = nq;
            end
        end
        hist.push_back(t_in);
        void'(hist.pop_front());
        exp_q.push_back({m_ovf, m_cnt[CW-1:0], m_q[CH-1:0]});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; drives inputs, clocks one edge, scoreboards, returns at the next negedge.
    task automatic step(input logic e, input logic ld, input logic [1:0] md,
                        input logic [CH-1:0] lv, input logic [CH-1:0] t);
        logic [EW-1:0] ex;
        ena = e; load = ld; mode = md; load_val = lv; t_in = t;
        @(posedge clk);
        model_edge();
        #1;
        ex = exp_q.pop_front();
        check("sb_q",   32'(q),          32'(ex[CH-1:0]));
        check("sb_cnt", 32'(toggle_cnt), 32'(ex[CH+CW-1:CH]));
        check("sb_ovf", 32'(cnt_ovf),    32'(ex[EW-1]));
        @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        check({name, "_q"},   32'(q),          32'h0);
        check({name, "_cnt"}, 32'(toggle_cnt), 32'h0);
        check({name, "_ovf"}, 32'(cnt_ovf),    32'h0);
    endtask

    // Entered at a negedge: asserts reset mid-cycle, checks it acts at once and holds.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 check_zero("rst_async");
        @(posedge clk); #1 check_zero("rst_hold1");
        @(posedge clk); #1 check_zero("rst_hold2");
        @(negedge clk);
        ena = 1'b0; load = 1'b0; mode = 2'b00; load_val = '0; t_in = '0;
        model_reset();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic          e;
        logic          ld;
        logic [1:0]    md;
        logic [CH-1:0] lv;
        logic [CH-1:0] t;
        logic [CH-1:0] eq;
        logic [CW-1:0] ec;
        logic          eo;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(logic e, logic ld, logic [1:0] md, logic [CH-1:0] lv,
                                logic [CH-1:0] t, logic [CH-1:0] eq, logic [CW-1:0] ec, logic eo);
        vec_t v;
        v.e = e; v.ld = ld; v.md = md; v.lv = lv; v.t = t; v.eq = eq; v.ec = ec; v.eo = eo;
        return v;
    endfunction

    initial begin
        // One edge per entry; expected values account for the two-edge synchroniser.
        tbl[0]  = mk(1, 1, 2'b00, 4'b1011, 4'b0000, 4'b1011, 4'd0, 0);
        tbl[1]  = mk(0, 1, 2'b00, 4'b0101, 4'b0000, 4'b1011, 4'd0, 0);
        tbl[2]  = mk(1, 0, 2'b10, 4'b0000, 4'b0000, 4'b1011, 4'd0, 0);
        tbl[3]  = mk(1, 0, 2'b00, 4'b0000, 4'b0000, 4'b1011, 4'd0, 0);
        tbl[4]  = mk(1, 1, 2'b11, 4'b0000, 4'b0001, 4'b0000, 4'd0, 0);
        tbl[5]  = mk(1, 0, 2'b11, 4'b0000, 4'b0001, 4'b0000, 4'd0, 0);
        tbl[6]  = mk(1, 0, 2'b11, 4'b0000, 4'b0001, 4'b0001, 4'd1, 0);
        tbl[7]  = mk(1, 0, 2'b11, 4'b0000, 4'b0001, 4'b0010, 4'd2, 0);
        tbl[8]  = mk(1, 1, 2'b11, 4'b1010, 4'b0001, 4'b1010, 4'd0, 0);
        tbl[9]  = mk(0, 0, 2'b11, 4'b0000, 4'b0001, 4'b1010, 4'd0, 0);
        tbl[10] = mk(1, 0, 2'b10, 4'b0000, 4'b0001, 4'b1010, 4'd0, 0);
        tbl[11] = mk(1, 0, 2'b00, 4'b0000, 4'b0001, 4'b1011, 4'd1, 0);
        tbl[12] = mk(1, 0, 2'b01, 4'b0000, 4'b0001, 4'b1011, 4'd1, 0);
        tbl[13] = mk(1, 0, 2'b00, 4'b0000, 4'b0000, 4'b1010, 4'd2, 0);
        tbl[14] = mk(1, 0, 2'b00, 4'b0000, 4'b0000, 4'b1011, 4'd3, 0);
        tbl[15] = mk(1, 0, 2'b00, 4'b0000, 4'b0000, 4'b1011, 4'd3, 0);

        rst_n = 1'b0; ena = 1'b0; load = 1'b0; mode = 2'b00; load_val = '0; t_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("init");
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].e, tbl[i].ld, tbl[i].md, tbl[i].lv, tbl[i].t);
            check($sformatf("tbl%0d_q", i),   32'(q),          32'(tbl[i].eq));
            check($sformatf("tbl%0d_cnt", i), 32'(toggle_cnt), 32'(tbl[i].ec));
            check($sformatf("tbl%0d_ovf", i), 32'(cnt_ovf),    32'(tbl[i].eo));
        end

        // Asynchronous reset from a loaded state.
        step(1, 1, 2'b00, 4'b1011, 4'b0000);
        check("pre_rst_q", 32'(q), 32'hb);
        do_reset();

        // Level mode: five-cycle pulse, first toggle on the third edge.
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 2'b00, 4'b0000, (i < 5) ? 4'b0001 : 4'b0000);
            if (i < 2) check("lvl_latency", 32'(q), 32'h0);
            if (i == 2) check("lvl_first", 32'(q), 32'h1);
        end
        check("lvl_q", 32'(q), 32'h1);
        check("lvl_cnt", 32'(toggle_cnt), 32'd5);

        // Edge mode: one toggle per held request, then no toggle on a 00->01 switch.
        do_reset();
        repeat (6) step(1, 0, 2'b01, 4'b0000, 4'b0011);
        check("edge_q", 32'(q), 32'h3);
        check("edge_cnt", 32'(toggle_cnt), 32'd1);
        step(1, 0, 2'b00, 4'b0000, 4'b0011);
        check("edge_lvl_q", 32'(q), 32'h0);
        repeat (2) step(1, 0, 2'b01, 4'b0000, 4'b0011);
        check("edge_sw_q", 32'(q), 32'h0);
        check("edge_sw_cnt", 32'(toggle_cnt), 32'd2);

        // Counter mode: 17 counts wrap q and toggle_cnt, setting the sticky flag.
        do_reset();
        for (int i = 0; i < 21; i++) begin
            step(1, 0, 2'b11, 4'b0000, (i < 17) ? 4'b0001 : 4'b0000);
            if (i == 16) check("cnt_ovf_clr", 32'(cnt_ovf), 32'h0);
            if (i == 17) check("cnt_ovf_set", 32'(cnt_ovf), 32'h1);
        end
        check("cnt_q", 32'(q), 32'h1);
        check("cnt_cnt", 32'(toggle_cnt), 32'd1);
        check("cnt_ovf", 32'(cnt_ovf), 32'h1);

        // Disabled and hold cycles freeze state; toggling resumes at once afterwards.
        repeat (4) step(0, 0, 2'b00, 4'b0000, 4'b1111);
        check("ena0_q", 32'(q), 32'h1);
        check("ena0_cnt", 32'(toggle_cnt), 32'd1);
        repeat (2) step(1, 0, 2'b10, 4'b0000, 4'b1111);
        check("hold_q", 32'(q), 32'h1);
        check("hold_cnt", 32'(toggle_cnt), 32'd1);
        step(1, 0, 2'b00, 4'b0000, 4'b1111);
        check("resume_q", 32'(q), 32'he);
        check("resume_cnt", 32'(toggle_cnt), 32'd2);
        check("resume_ovf", 32'(cnt_ovf), 32'h1);

        // Load clears the sticky flag.
        step(1, 1, 2'b11, 4'b1010, 4'b0001);
        check("load_q", 32'(q), 32'ha);
        check("load_ovf", 32'(cnt_ovf), 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
                 2'($urandom_range(0, 3)), CH'($urandom_range(0, 15)),
                 (i % 3 == 0) ? CH'($urandom_range(0, 15)) : t_in);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
